sbox_layer_arbiter: RTL
=======================

Name: sbox_layer_arbiter

Overview:
Shares one DES S-box substitution layer (sbox1..sbox8 in parallel, 48-bit in -> 32-bit out) between NREQ independent round engines, such as the encrypt and decrypt Feistel cores. It uses a round-robin grant and a single registered response slot. Each requester gets a valid/ready request channel and its own response-valid line on a shared response data bus. The block sits between the F-function key-mix XOR stage and the P-permutation stage of each core.

Parameters:
NREQ, 2, number of requesters; legal range 2..4.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  NREQ  bit i: requester i presents a 48-bit S-layer input.
req_data  in  48*NREQ  requester i input at [48*i+47 : 48*i].
req_ready  out  NREQ  one-hot or zero; bit i high means requester i is accepted this cycle.
rsp_valid  out  NREQ  one-hot or zero; bit i high means rsp_data belongs to requester i.
rsp_data  out  32  registered S-layer result.
rsp_ready  in  NREQ  bit i: requester i consumes its response.

Behaviour:
- Datapath mapping:
  - chunk k (k=0..7) = in[47-6k : 42-6k] drives sbox(k+1).
  - sbox(k+1) output goes to out[31-4k : 28-4k].
  - Row and column decode happens inside each sbox.
- State:
  - rsp_full flag.
  - owner index (2 bits).
  - rsp_data register.
  - rr_ptr (2 bits) = index with highest priority this cycle.
- Reset, applied at the next edge regardless of activity:
  - rsp_full=0, rsp_valid=0, rsp_data=0, owner=0, rr_ptr=0.
  - An in-flight response is discarded and not replayed.
- Slot availability: free = !rsp_full || rsp_ready[owner]. The non-owner rsp_ready bits are ignored.
- Grant (combinational):
  - If free, scan req_valid starting at rr_ptr, wrapping modulo NREQ. The first set bit i gets req_ready[i]=1.
  - Otherwise req_ready is all zero.
  - req_ready must never depend on req_ready; it may depend on req_valid.
- On a grant edge:
  - rsp_data <= S(req_data[i]).
  - owner <= i, rsp_full <= 1.
  - rr_ptr <= (i+1) mod NREQ.
- Edge with no grant: if rsp_full && rsp_ready[owner], then rsp_full <= 0. rr_ptr is unchanged.
- rsp_valid[j] = rsp_full && (owner==j).
- rsp_data is held stable while rsp_full and not consumed.
- Latency and throughput:
  - A request accepted at edge N has its response visible after edge N (rsp_valid high in cycle N+1).
  - Simultaneous drain and grant in the same cycle is allowed, giving 1 result per cycle when rsp_ready is held high.
- Fairness: with all requesters continuously valid and rsp_ready high, grants rotate 0,1,..,NREQ-1,0,...
- Requests are never reordered. A requester may drop req_valid without penalty; there is no lock or retry.
- Request-side X on unselected req_data must not propagate.

Test Plan:
- Reset, then requester 0 sends req_data=48'h0 with rsp_ready=1 -> req_ready[0]=1 same cycle; next cycle rsp_valid=2'b01, rsp_data=32'hEFA72C4D.
- Requester 1 sends 48'hFFFFFFFFFFFF -> rsp_valid=2'b10, rsp_data=32'hD9CE3DCB.
- Both requesters valid continuously for 6 cycles, rsp_ready=11 -> grants alternate 0,1,0,1,0,1 with one response per cycle, each carrying the correct owner bit.
- Response stall:
  - Requester 0 result pending with rsp_ready[0]=0 for 3 cycles while requester 1 is valid and asserts rsp_ready[1]=1.
  - Required: req_ready=00, rsp_data held, and requester 1 is granted in the cycle rsp_ready[0] rises.
- Assert rst while rsp_valid=01 and req_valid=11 -> next cycle rsp_valid=00, rsp_data=0; first post-reset grant goes to requester 0.
- NREQ=3, only requester 2 valid after requester 0 was last granted -> requester 2 is granted, and rr_ptr then gives requester 0 priority.

Source files
------------

// File: rtl/sbox_layer_arbiter_if.sv
// sbox_layer_arbiter_if
//    Request/response bundle between NREQ round engines and the shared
//    DES S-box layer.
//    req_valid [NREQ]     : requester i presents a 48-bit S-layer input
//    req_data  [48*NREQ]  : requester i input at [48*i+47 : 48*i]
//    req_ready [NREQ]     : one-hot/zero grant, requester i accepted this cycle
//    rsp_valid [NREQ]     : one-hot/zero, rsp_data belongs to requester i
//    rsp_data  [32]       : registered S-layer result
//    rsp_ready [NREQ]     : requester i consumes its response
//    slave  = arbiter side, master = requester side.
interface sbox_layer_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [48*NREQ-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      rsp_valid;
   logic [31:0]          rsp_data;
   logic [NREQ-1:0]      rsp_ready;

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/sbox_layer_arbiter.sv
// sbox_layer_arbiter
//    One DES S-box substitution layer (sbox1..sbox8, 48 -> 32 bits) shared
//    by NREQ round engines. Round-robin grant into a single registered
//    response slot; the slot can drain and refill in the same cycle, so a
//    continuously-ready consumer sees one result per cycle.
//    clk : rising-edge clock
//    rst : synchronous reset, active high
//    bus : sbox_layer_arbiter_if.slave (request channels, response bus)
module sbox_layer_arbiter #(
   parameter int NREQ = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   sbox_layer_arbiter_if.slave   bus
);
   localparam logic [1:0] LAST_IDX = 2'(NREQ - 1);

   // Each entry is one S-box, 64 nibbles, row-major (row*16+col), with
   // element 0 in the most significant nibble.
   localparam logic [255:0] SBOX_TAB [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   logic             r_rsp_full;
   logic [1:0]       r_owner;
   logic [1:0]       r_rr_ptr;
   logic [31:0]      r_rsp_data;

   logic [NREQ-1:0]  w_rsp_valid;
   logic [NREQ-1:0]  w_grant;
   logic [1:0]       w_grant_idx;
   logic             w_grant_any;
   logic             w_owner_ready;
   logic             w_free;
   logic [47:0]      w_masked [NREQ];
   logic [47:0]      w_sel_data;
   logic [31:0]      w_sbox_out;

   genvar gi;

   // Per-requester response valid and grant-masked request data. Masking
   // with a known-zero grant keeps X on unselected inputs out of the layer.
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign w_rsp_valid[gi] = r_rsp_full && (r_owner == 2'(gi));
         assign w_masked[gi]    = w_grant[gi] ? bus.req_data[48*gi +: 48] : 48'h0;
      end
   endgenerate

   always_comb begin
      w_sel_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         w_sel_data = w_sel_data | w_masked[j];
      end
   end

   // Only the current owner's rsp_ready can free the slot.
   assign w_owner_ready = |(w_rsp_valid & bus.rsp_ready);
   assign w_free        = !r_rsp_full || w_owner_ready;

   // Round-robin: first scan indices rr_ptr..NREQ-1, then wrap to 0..rr_ptr-1.
   always_comb begin
      w_grant     = '0;
      w_grant_idx = '0;
      w_grant_any = 1'b0;
      if (w_free) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!w_grant_any && bus.req_valid[j] && (2'(j) >= r_rr_ptr)) begin
               w_grant[j]  = 1'b1;
               w_grant_idx = 2'(j);
               w_grant_any = 1'b1;
            end
         end
         for (int j = 0; j < NREQ; j++) begin
            if (!w_grant_any && bus.req_valid[j] && (2'(j) < r_rr_ptr)) begin
               w_grant[j]  = 1'b1;
               w_grant_idx = 2'(j);
               w_grant_any = 1'b1;
            end
         end
      end
   end

   // Eight S-boxes in parallel. Chunk k is in[47-6k:42-6k]; row is the
   // outer bit pair, column the inner four bits. ~elem addresses the table
   // from its most significant nibble.
   generate
      for (gi = 0; gi < 8; gi++) begin : g_sbox
         logic [5:0] w_chunk;
         logic [5:0] w_elem;
         assign w_chunk = w_sel_data[47-6*gi -: 6];
         assign w_elem  = {w_chunk[5], w_chunk[0], w_chunk[4:1]};
         assign w_sbox_out[31-4*gi -: 4] = SBOX_TAB[gi][{~w_elem, 2'b00} +: 4];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_full <= 1'b0;
         r_owner    <= 2'd0;
         r_rr_ptr   <= 2'd0;
         r_rsp_data <= 32'h0;
      end else if (w_grant_any) begin
         r_rsp_full <= 1'b1;
         r_owner    <= w_grant_idx;
         r_rsp_data <= w_sbox_out;
         r_rr_ptr   <= (w_grant_idx == LAST_IDX) ? 2'd0 : w_grant_idx + 2'd1;
      end else if (r_rsp_full && w_owner_ready) begin
         r_rsp_full <= 1'b0;
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
endmodule
